// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared types and constants for the hue-wheel colour fader
package color_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    PH_R_G_UP = 3'd0,
    PH_R_DN   = 3'd1,
    PH_B_UP   = 3'd2,
    PH_G_DN   = 3'd3,
    PH_R_UP   = 3'd4,
    PH_B_DN   = 3'd5
  } phase_t;

  // Encodings 6 and 7 cannot be produced; if they ever appear they restart the wheel.
  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PH_R_G_UP: return PH_R_DN;
      PH_R_DN:   return PH_B_UP;
      PH_B_UP:   return PH_G_DN;
      PH_G_DN:   return PH_R_UP;
      PH_R_UP:   return PH_B_DN;
      default:   return PH_R_G_UP;
    endcase
  endfunction

endpackage

// File: rtl/color_fader_if.sv
// rtl/color_fader_if.sv - control and colour-output bundle of the fader
interface color_fader_if import color_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             en;
  logic             tick;
  logic [2:0]       phase;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] g_duty;
  logic [WIDTH-1:0] b_duty;
  logic             r_pwm;
  logic             g_pwm;
  logic             b_pwm;
  logic             wrap;

  modport master (
    output en, tick,
    input  phase, r_duty, g_duty, b_duty, r_pwm, g_pwm, b_pwm, wrap
  );

  modport slave (
    input  en, tick,
    output phase, r_duty, g_duty, b_duty, r_pwm, g_pwm, b_pwm, wrap
  );
endinterface

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one registered PWM comparator against the shared counter
module pwm_channel import color_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] pwm_cnt,
  output logic             pwm
);

  logic pwm_d;
  logic pwm_q;

  // Strict compare: duty 0 never fires, duty D fires on counts 0..D-1.
  always_comb begin
    pwm_d = (duty > pwm_cnt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/color_fader.sv
// rtl/color_fader.sv - tick-driven six-phase RGB ramp with three PWM outputs
module color_fader import color_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = 1
) (
  input  logic         clk,
  input  logic         rst,
  color_fader_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX       = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STEP_V    = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LVL_LIMIT = MAX - STEP_V;

  logic             tick_q, tick_d;
  phase_t           phase_q, phase_d;
  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;

  logic             tick_rise;
  logic             advance;
  logic [WIDTH-1:0] r_duty, g_duty, b_duty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q    <= 1'b0;
      phase_q   <= PH_R_G_UP;
      lvl_q     <= '0;
      wrap_q    <= 1'b0;
      pwm_cnt_q <= '0;
    end else begin
      tick_q    <= tick_d;
      phase_q   <= phase_d;
      lvl_q     <= lvl_d;
      wrap_q    <= wrap_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Comparing against MAX-STEP instead of adding first keeps lvl from overflowing.
  always_comb begin
    tick_d    = bus.tick;
    tick_rise = bus.tick & ~tick_q;
    advance   = bus.en & tick_rise;
    phase_d   = phase_q;
    lvl_d     = lvl_q;
    wrap_d    = 1'b0;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    if (advance) begin
      if (lvl_q >= LVL_LIMIT) begin
        lvl_d   = '0;
        phase_d = next_phase(phase_q);
        wrap_d  = (phase_q == PH_B_DN);
      end else begin
        lvl_d   = lvl_q + STEP_V;
      end
    end
  end

  always_comb begin
    r_duty = MAX;
    g_duty = lvl_q;
    b_duty = '0;
    case (phase_q)
      PH_R_DN: begin
        r_duty = MAX - lvl_q;
        g_duty = MAX;
        b_duty = '0;
      end
      PH_B_UP: begin
        r_duty = '0;
        g_duty = MAX;
        b_duty = lvl_q;
      end
      PH_G_DN: begin
        r_duty = '0;
        g_duty = MAX - lvl_q;
        b_duty = MAX;
      end
      PH_R_UP: begin
        r_duty = lvl_q;
        g_duty = '0;
        b_duty = MAX;
      end
      PH_B_DN: begin
        r_duty = MAX;
        g_duty = '0;
        b_duty = MAX - lvl_q;
      end
      default: begin
        r_duty = MAX;
        g_duty = lvl_q;
        b_duty = '0;
      end
    endcase
  end

  pwm_channel #(.WIDTH(WIDTH)) u_pwm_r (
    .clk     (clk),
    .rst     (rst),
    .duty    (r_duty),
    .pwm_cnt (pwm_cnt_q),
    .pwm     (bus.r_pwm)
  );

  pwm_channel #(.WIDTH(WIDTH)) u_pwm_g (
    .clk     (clk),
    .rst     (rst),
    .duty    (g_duty),
    .pwm_cnt (pwm_cnt_q),
    .pwm     (bus.g_pwm)
  );

  pwm_channel #(.WIDTH(WIDTH)) u_pwm_b (
    .clk     (clk),
    .rst     (rst),
    .duty    (b_duty),
    .pwm_cnt (pwm_cnt_q),
    .pwm     (bus.b_pwm)
  );

  assign bus.phase  = phase_q;
  assign bus.r_duty = r_duty;
  assign bus.g_duty = g_duty;
  assign bus.b_duty = b_duty;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_color_fader.sv
// tb/tb_color_fader.sv - randomized and directed bench for color_fader (WIDTH=4, STEP=1 and STEP=4)
module tb_color_fader;

  localparam int W    = 4;
  localparam int MAXV = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic tick = 1'b0;

  always #5 clk = ~clk;

  color_fader_if #(.WIDTH(W)) bus_a ();
  color_fader_if #(.WIDTH(W)) bus_b ();

  assign bus_a.en   = en;
  assign bus_a.tick = tick;
  assign bus_b.en   = en;
  assign bus_b.tick = tick;

  color_fader #(.WIDTH(W), .STEP(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  color_fader #(.WIDTH(W), .STEP(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: a ramp is a position around the wheel; phase and level derive from it.
  int       m_pos_a = 0;
  int       m_pos_b = 0;
  bit       m_prev = 0;
  bit       m_wrap_a = 0;
  bit       m_wrap_b = 0;
  int       m_cnt = 0;
  bit [2:0] m_pwm_a = 0;
  bit [2:0] m_pwm_b = 0;

  function automatic int per_phase(int step);
    return (MAXV - step + step - 1) / step + 1;
  endfunction

  function automatic int duty_of(int pos, int step, int ch);
    int n, ph, l, r, g, b;
    n = per_phase(step);
    ph = pos / n;
    l = (pos % n) * step;
    case (ph)
      0: begin r = MAXV;     g = l;        b = 0;        end
      1: begin r = MAXV - l; g = MAXV;     b = 0;        end
      2: begin r = 0;        g = MAXV;     b = l;        end
      3: begin r = 0;        g = MAXV - l; b = MAXV;     end
      4: begin r = l;        g = 0;        b = MAXV;     end
      default: begin r = MAXV; g = 0;      b = MAXV - l; end
    endcase
    return (ch == 0) ? r : (ch == 1) ? g : b;
  endfunction

  function automatic logic [14:0] model_vec(int pos, int step);
    return {3'(pos / per_phase(step)), 4'(duty_of(pos, step, 0)),
            4'(duty_of(pos, step, 1)), 4'(duty_of(pos, step, 2))};
  endfunction

  function automatic logic [14:0] dut_vec_a();
    return {bus_a.phase, bus_a.r_duty, bus_a.g_duty, bus_a.b_duty};
  endfunction

  function automatic logic [14:0] dut_vec_b();
    return {bus_b.phase, bus_b.r_duty, bus_b.g_duty, bus_b.b_duty};
  endfunction

  task automatic cycle();
    bit rise;
    @(posedge clk);
    if (!rst) begin
      m_pos_a = 0; m_pos_b = 0; m_prev = 0; m_wrap_a = 0; m_wrap_b = 0;
      m_cnt = 0; m_pwm_a = 0; m_pwm_b = 0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        m_pwm_a[2-ch] = (duty_of(m_pos_a, 1, ch) > m_cnt);
        m_pwm_b[2-ch] = (duty_of(m_pos_b, 4, ch) > m_cnt);
      end
      rise = tick && !m_prev;
      m_prev = tick;
      m_wrap_a = 0;
      m_wrap_b = 0;
      if (en && rise) begin
        m_pos_a++;
        if (m_pos_a == 6 * per_phase(1)) begin m_pos_a = 0; m_wrap_a = 1; end
        m_pos_b++;
        if (m_pos_b == 6 * per_phase(4)) begin m_pos_b = 0; m_wrap_b = 1; end
      end
      m_cnt = (m_cnt + 1) % (MAXV + 1);
    end
    #1;
  endtask

  task automatic pulse();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; tick = 1'b0;
    repeat (3) cycle();
    total_cnt++;
    if (dut_vec_a() !== 15'b000_1111_0000_0000)
      $display("FAIL reset_state_a: got %h expected %h", dut_vec_a(), 15'b000_1111_0000_0000);
    else pass_cnt++;
    total_cnt++;
    if (dut_vec_b() !== 15'b000_1111_0000_0000)
      $display("FAIL reset_state_b: got %h expected %h", dut_vec_b(), 15'b000_1111_0000_0000);
    else pass_cnt++;
    total_cnt++;
    if ({bus_a.r_pwm, bus_a.g_pwm, bus_a.b_pwm} !== 3'b000)
      $display("FAIL reset_pwm: got %b expected 000", {bus_a.r_pwm, bus_a.g_pwm, bus_a.b_pwm});
    else pass_cnt++;
    total_cnt++;
    if (bus_a.wrap !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", bus_a.wrap);
    else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_single_steps();
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick = 1'b1;
      cycle();
      total_cnt++;
      if (bus_a.g_duty !== 4'(i)) $display("FAIL step_g_duty: got %0d expected %0d", bus_a.g_duty, i);
      else pass_cnt++;
      tick = 1'b0;
      cycle();
      total_cnt++;
      if (dut_vec_a() !== model_vec(m_pos_a, 1))
        $display("FAIL step_hold: got %h expected %h", dut_vec_a(), model_vec(m_pos_a, 1));
      else pass_cnt++;
    end
    tick = 1'b1;
    repeat (5) begin
      cycle();
      total_cnt++;
      if (bus_a.g_duty !== 4'd4) $display("FAIL long_tick: got %0d expected 4", bus_a.g_duty);
      else pass_cnt++;
    end
    tick = 1'b0;
    cycle();
  endtask

  task automatic test_phase_boundary();
    int wraps;
    for (int i = 0; i < 100 && m_pos_a != 14; i++) pulse();
    total_cnt++;
    if (dut_vec_a() !== 15'b000_1111_1110_0000)
      $display("FAIL lvl14: got %h expected %h", dut_vec_a(), 15'b000_1111_1110_0000);
    else pass_cnt++;
    tick = 1'b1;
    cycle();
    total_cnt++;
    if (dut_vec_a() !== 15'b001_1111_1111_0000)
      $display("FAIL phase_cross: got %h expected %h", dut_vec_a(), 15'b001_1111_1111_0000);
    else pass_cnt++;
    tick = 1'b0;
    cycle();
    do_reset();
    wraps = 0;
    for (int i = 0; i < 180; i++) begin
      tick = (i % 2 == 0);
      cycle();
      if (bus_a.wrap === 1'b1) wraps++;
      total_cnt++;
      if (bus_a.wrap !== m_wrap_a || bus_b.wrap !== m_wrap_b)
        $display("FAIL wrap_pulse: got %b%b expected %b%b", bus_a.wrap, bus_b.wrap, m_wrap_a, m_wrap_b);
      else pass_cnt++;
    end
    tick = 1'b0;
    total_cnt++;
    if (wraps !== 1) $display("FAIL wrap_count: got %0d expected 1", wraps);
    else pass_cnt++;
    total_cnt++;
    if (dut_vec_a() !== 15'b000_1111_0000_0000)
      $display("FAIL full_rev: got %h expected %h", dut_vec_a(), 15'b000_1111_0000_0000);
    else pass_cnt++;
  endtask

  task automatic test_en_gating();
    logic [14:0] snap;
    pulse(); pulse();
    snap = model_vec(m_pos_a, 1);
    en = 1'b0;
    repeat (4) pulse();
    total_cnt++;
    if (dut_vec_a() !== snap) $display("FAIL en_low_hold: got %h expected %h", dut_vec_a(), snap);
    else pass_cnt++;
    tick = 1'b1;
    cycle();
    en = 1'b1;
    repeat (3) cycle();
    total_cnt++;
    if (dut_vec_a() !== snap) $display("FAIL en_rise_high_tick: got %h expected %h", dut_vec_a(), snap);
    else pass_cnt++;
    tick = 1'b0;
    cycle();
    tick = 1'b1;
    cycle();
    total_cnt++;
    if (dut_vec_a() !== model_vec(m_pos_a, 1) || dut_vec_a() === snap)
      $display("FAIL en_next_edge: got %h expected %h", dut_vec_a(), model_vec(m_pos_a, 1));
    else pass_cnt++;
    tick = 1'b0;
    cycle();
  endtask

  task automatic test_pwm();
    int hr, hg, hb;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 100 && m_pos_a != 64; i++) pulse();
    total_cnt++;
    if (dut_vec_a() !== 15'b100_0100_0000_1111)
      $display("FAIL pwm_setup: got %h expected %h", dut_vec_a(), 15'b100_0100_0000_1111);
    else pass_cnt++;
    cycle(); cycle();
    hr = 0; hg = 0; hb = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      hr += int'(bus_a.r_pwm); hg += int'(bus_a.g_pwm); hb += int'(bus_a.b_pwm);
      total_cnt++;
      if ({bus_a.r_pwm, bus_a.g_pwm, bus_a.b_pwm} !== m_pwm_a)
        $display("FAIL pwm_cycle: got %b expected %b", {bus_a.r_pwm, bus_a.g_pwm, bus_a.b_pwm}, m_pwm_a);
      else pass_cnt++;
    end
    total_cnt++;
    if (hr !== 4) $display("FAIL pwm_r_count: got %0d expected 4", hr);
    else pass_cnt++;
    total_cnt++;
    if (hg !== 0) $display("FAIL pwm_g_count: got %0d expected 0", hg);
    else pass_cnt++;
    total_cnt++;
    if (hb !== 15) $display("FAIL pwm_b_count: got %0d expected 15", hb);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_ramp();
    int exp_g[3] = '{4, 8, 12};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 100 && m_pos_a != 50; i++) pulse();
    tick = 1'b1;
    rst = 1'b0;
    cycle();
    total_cnt++;
    if (dut_vec_a() !== 15'b000_1111_0000_0000 || dut_vec_b() !== 15'b000_1111_0000_0000)
      $display("FAIL reset_wins: got %h/%h expected %h", dut_vec_a(), dut_vec_b(), 15'b000_1111_0000_0000);
    else pass_cnt++;
    rst = 1'b1;
    tick = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      cycle();
      total_cnt++;
      if (bus_b.g_duty !== 4'(exp_g[i])) $display("FAIL step4_lvl: got %0d expected %0d", bus_b.g_duty, exp_g[i]);
      else pass_cnt++;
      tick = 1'b0;
      cycle();
    end
    tick = 1'b1;
    cycle();
    total_cnt++;
    if (dut_vec_b() !== 15'b001_1111_1111_0000)
      $display("FAIL step4_phase: got %h expected %h", dut_vec_b(), 15'b001_1111_1111_0000);
    else pass_cnt++;
    tick = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      tick = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 199) != 0);
      cycle();
      total_cnt++;
      if (dut_vec_a() !== model_vec(m_pos_a, 1) || dut_vec_b() !== model_vec(m_pos_b, 4))
        $display("FAIL rand_state: got %h/%h expected %h/%h", dut_vec_a(), dut_vec_b(),
                 model_vec(m_pos_a, 1), model_vec(m_pos_b, 4));
      else pass_cnt++;
      total_cnt++;
      if ({bus_a.r_pwm, bus_a.g_pwm, bus_a.b_pwm, bus_b.r_pwm, bus_b.g_pwm, bus_b.b_pwm,
           bus_a.wrap, bus_b.wrap} !== {m_pwm_a, m_pwm_b, m_wrap_a, m_wrap_b})
        $display("FAIL rand_outputs: got %b expected %b",
                 {bus_a.r_pwm, bus_a.g_pwm, bus_a.b_pwm, bus_b.r_pwm, bus_b.g_pwm, bus_b.b_pwm,
                  bus_a.wrap, bus_b.wrap}, {m_pwm_a, m_pwm_b, m_wrap_a, m_wrap_b});
      else pass_cnt++;
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_steps();
    test_phase_boundary();
    test_en_gating();
    test_pwm();
    test_reset_mid_ramp();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/color_fader.md
# color_fader

Hue-wheel fader that sits directly downstream of `Counter`. Its slow `clkout` drives the `tick` input, and each rising edge of `tick` advances a 6-phase RGB colour ramp by one step. The three resulting duty values feed internal PWM generators, which drive the LED colour outputs of the Color_Show design.

## Interface

Parameters:
- `WIDTH`, default 8: bit width of the duty values and the PWM counter. `MAX = 2**WIDTH-1`.
- `STEP`, default 1: ramp increment per tick. Legal range is 1 ≤ STEP ≤ MAX.

Ports:
- `clk`  in  1: the only clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-low reset (`rst = 0` at a rising `clk` resets the block).
- `en`  in  1: when high, the ramp advances on `tick` edges.
- `tick`  in  1: `Counter.clkout`, synchronous to `clk`. Only its rising edge is used.
- `phase`  out  3: current hue phase, 0..5.
- `r_duty`, `g_duty`, `b_duty`  out  WIDTH: current duty per channel.
- `r_pwm`, `g_pwm`, `b_pwm`  out  1: PWM outputs, registered.
- `wrap`  out  1: one-cycle pulse when the phase goes from 5 to 0.

## Operation

- **Tick edge detect:** `tick_q` is a register holding the previous-cycle value of `tick`. `tick_rise = tick & ~tick_q`. If `tick` is held high for N cycles, that counts as exactly one edge.
- **Ramp state:**
  - `phase` is 3 bits, 0..5.
  - `lvl` is WIDTH bits.
  - `advance = en & tick_rise`.
- **On `advance`:**
  - If `lvl >= MAX-STEP`: `lvl <= 0`, and `phase <= phase+1`. Phase 5 goes to 0, and `wrap` is set to 1 for that cycle.
  - Otherwise: `lvl <= lvl+STEP`.
  - The comparison is done without overflow, so `lvl` never exceeds MAX.
- **Duty decode (combinational from `phase`/`lvl`, no added latency), per phase:**
  - Phase 0: R=MAX, G=lvl, B=0
  - Phase 1: R=MAX-lvl, G=MAX, B=0
  - Phase 2: R=0, G=MAX, B=lvl
  - Phase 3: R=0, G=MAX-lvl, B=MAX
  - Phase 4: R=lvl, G=0, B=MAX
  - Phase 5: R=MAX, G=0, B=MAX-lvl
  - Phase values 6 and 7 are unreachable. If they occur, decode them as phase 0.
- **PWM:**
  - `pwm_cnt` is a WIDTH-bit counter that runs freely every cycle, independent of `en`, and wraps from MAX to 0.
  - Each channel: `x_pwm <= (x_duty > pwm_cnt)`.
  - Duty 0 gives an output that is always low. Duty D gives D high cycles per 2**WIDTH-cycle period.
- **`en` low:**
  - `phase` and `lvl` hold; ticks are ignored.
  - `tick_q` keeps tracking `tick`, so re-enabling while `tick` is high does not produce a false edge.
  - PWM keeps running.
- **Reset:**
  - Takes priority over everything else.
  - Register values: `phase=0`, `lvl=0`, `tick_q=0`, `pwm_cnt=0`, `wrap=0`, all `x_pwm=0`.
  - Resulting duties: R=MAX, G=0, B=0.
  - Reset in the middle of a ramp abandons the ramp immediately.

## Timing

- A `tick` rise sampled at edge k updates `phase`/`lvl`/`duty` at edge k, so they are visible after k.
- `x_pwm` reflects a new duty from edge k+1 onward.
- `wrap` is high during the cycle following edge k, and only that cycle.
- With STEP=1, each phase lasts MAX ticks, and a full revolution takes 6·MAX ticks.
- The `Counter` period sets the fade speed. This block imposes no minimum spacing between ticks beyond one low cycle between edges.

## Structure

- **Package `color_pkg`:**
  - `phase_t` enum: `PH_R_G_UP`, `PH_R_DN`, `PH_B_UP`, `PH_G_DN`, `PH_R_UP`, `PH_B_DN`.
  - Default `WIDTH` constant.
- **Sub-module `pwm_channel`:** compares a duty value against a shared `pwm_cnt` and registers the output. Instantiated three times.
- **Top level:** edge detect, ramp FSM, duty decode, and the shared PWM counter.

## Test plan

Benches use `WIDTH=4` (MAX=15) and `STEP=1` unless stated otherwise.

- **Reset:** hold `rst=0` for 3 cycles → `phase=0`, duties R/G/B = 15/0/0, all `x_pwm=0`, `wrap=0`.
- **Single steps:** 3 tick pulses with `en=1` → `g_duty` 1, 2, 3, each updating at the edge that samples the tick high. Hold `tick` high for 5 cycles → exactly one step.
- **Phase boundary:** at `lvl=14` in phase 0, one tick → `phase=1`, `lvl=0`, duties R/G/B = 15/15/0. Run 90 ticks from reset → one `wrap` pulse, state returns to `phase=0`, `lvl=0`.
- **`en` gating:** `en=0` during 4 ticks → state unchanged. Raise `en` while `tick` is high → no step until the next rising edge.
- **PWM:** set `r_duty=4` (phase 4, `lvl=4`) → `r_pwm` high for exactly 4 of every 16 cycles. `b_duty=15` → high for 15 of 16. `g_duty=0` → never high.
- **Reset mid-ramp:** assert `rst=0` in phase 3 while a tick edge arrives in the same cycle → reset wins, `phase=0`, `lvl=0`. With `STEP=4`, `lvl` sequence is 0, 4, 8 (since 8 < MAX-STEP=11), then 12 (since 12 ≥ 11), then the next tick advances the phase.
